// File: rtl/frame_buffer_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frame_buffer_writer
//
// Owns the 256x240 frame buffer (one palette index per pixel) that sits just
// upstream of the VGA scan-out stage. The PPU pixel stream arrives in raster
// order over valid/ready, is staged in a small FIFO and drained into the RAM
// one entry per cycle. A separate read port serves scan-out with a fixed
// one-cycle latency.
//
// Ports
//   vga_clk           single clock
//   reset             synchronous, active-high
//   pix_valid         PPU pixel valid
//   pix_ready         a pixel can be accepted this cycle
//   pix_color         pixel palette index
//   pix_frame_start   pixel is (0,0) of a new frame (qualified by valid&ready)
//   read_pixel_num    scan-out read address {y[7:0], x[7:0]}
//   read_pixel_color  RAM data for the previous cycle's read_pixel_num
//   frame_done        one-cycle pulse after the last pixel of a frame is written
//   sync_error        sticky flag: a frame was too short or too long
//   fifo_level        current FIFO occupancy
// -----------------------------------------------------------------------------
module frame_buffer_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int PIXELS     = 61440,
    parameter int COLOR_W    = 6
) (
    input  logic                          vga_clk,
    input  logic                          reset,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [COLOR_W-1:0]            pix_color,
    input  logic                          pix_frame_start,
    input  logic [15:0]                   read_pixel_num,
    output logic [COLOR_W-1:0]            read_pixel_color,
    output logic                          frame_done,
    output logic                          sync_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = COLOR_W + 1;

    localparam logic [15:0]      LAST_ADDR  = 16'(PIXELS - 1);
    localparam logic [15:0]      RAM_WORDS  = 16'(PIXELS);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        WAIT_SOF  = 2'b00,
        WRITING   = 2'b01,
        FRAME_END = 2'b10
    } state_t;

    // Input FIFO
    logic [ENTRY_W-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   count_r;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_s;
    logic               head_sof_s;
    logic [COLOR_W-1:0] head_color_s;

    // Write side control
    state_t             state_r;
    state_t             state_nxt_s;
    logic [15:0]        wr_addr_r;
    logic [15:0]        wr_addr_nxt_s;
    logic               ram_we_s;
    logic [15:0]        ram_addr_s;
    logic [COLOR_W-1:0] ram_din_s;
    logic               done_nxt_s;
    logic               sync_set_s;

    // Frame buffer storage (deliberately not reset)
    logic [COLOR_W-1:0] ram_r [PIXELS];

    // Ready comes from the registered count so it never depends on pix_valid.
    assign pix_ready    = !reset && (count_r != FULL_LEVEL);
    assign push_s       = pix_valid && pix_ready;
    // The drain never stalls: any buffered entry is consumed on the next edge.
    assign pop_s        = (count_r != {LVL_W{1'b0}});
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign head_sof_s   = head_s[ENTRY_W-1];
    assign head_color_s = head_s[COLOR_W-1:0];
    assign fifo_level   = count_r;

    // FIFO storage write (no reset needed, validity tracked by count_r)
    always_ff @(posedge vga_clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {pix_frame_start, pix_color};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + LVL_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - LVL_W'(1);
            end
        end
    end

    // Frame sequencing: decide what the popped entry does to the RAM
    always_comb begin
        state_nxt_s   = state_r;
        wr_addr_nxt_s = wr_addr_r;
        ram_we_s      = 1'b0;
        ram_addr_s    = wr_addr_r;
        ram_din_s     = head_color_s;
        done_nxt_s    = 1'b0;
        sync_set_s    = 1'b0;
        if (pop_s) begin
            case (state_r)
                WAIT_SOF: begin
                    if (head_sof_s) begin
                        ram_we_s      = 1'b1;
                        ram_addr_s    = 16'd0;
                        wr_addr_nxt_s = 16'd1;
                        state_nxt_s   = WRITING;
                    end else begin
                        // Mid-frame pixels before any start marker are dropped.
                        ram_we_s      = 1'b0;
                    end
                end
                WRITING: begin
                    if (head_sof_s) begin
                        // New frame arrived before the old one completed.
                        sync_set_s    = (wr_addr_r != 16'd0);
                        ram_we_s      = 1'b1;
                        ram_addr_s    = 16'd0;
                        wr_addr_nxt_s = 16'd1;
                    end else begin
                        ram_we_s = 1'b1;
                        if (wr_addr_r == LAST_ADDR) begin
                            done_nxt_s    = 1'b1;
                            wr_addr_nxt_s = 16'd0;
                            state_nxt_s   = FRAME_END;
                        end else begin
                            wr_addr_nxt_s = wr_addr_r + 16'd1;
                        end
                    end
                end
                FRAME_END: begin
                    if (head_sof_s) begin
                        ram_we_s      = 1'b1;
                        ram_addr_s    = 16'd0;
                        wr_addr_nxt_s = 16'd1;
                        state_nxt_s   = WRITING;
                    end else begin
                        // Pixels beyond the end of a frame are dropped.
                        sync_set_s    = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s   = WAIT_SOF;
                    wr_addr_nxt_s = 16'd0;
                end
            endcase
        end else begin
            state_nxt_s   = state_r;
            wr_addr_nxt_s = wr_addr_r;
        end
    end

    // Write-side state, address counter and status flags
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_r    <= WAIT_SOF;
            wr_addr_r  <= 16'd0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wr_addr_r  <= wr_addr_nxt_s;
            frame_done <= done_nxt_s;
            sync_error <= sync_error | sync_set_s;
        end
    end

    // Frame buffer write port
    always_ff @(posedge vga_clk) begin
        if (ram_we_s) begin
            ram_r[ram_addr_s] <= ram_din_s;
        end
    end

    // Scan-out read port: registered, returns pre-write data on a collision
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            read_pixel_color <= {COLOR_W{1'b0}};
        end else if (read_pixel_num < RAM_WORDS) begin
            read_pixel_color <= ram_r[read_pixel_num];
        end else begin
            read_pixel_color <= {COLOR_W{1'b0}};
        end
    end

endmodule
